// File: rtl/cmac_pkg.sv
// Shared definitions for the complex MAC sequencer.
//   cmac_state_t : sequencer FSM states
//   acc_width()  : accumulator width = integer + fractional + guard bits
//   cnt_width()  : tap counter width able to hold 0..N_TAPS
//   sat_clamp()  : clamp a sign-extended value into a W-bit signed range
package cmac_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } cmac_state_t;

   localparam int SAT_EXT_W = 64;

   function automatic int acc_width(input int qi, input int qf, input int guard);
      return qi + qf + guard;
   endfunction

   function automatic int cnt_width(input int n_taps);
      return (n_taps < 1) ? 1 : $clog2(n_taps + 1);
   endfunction

   // Callers detect clamping by comparing the result with the input.
   function automatic logic signed [SAT_EXT_W-1:0] sat_clamp(
      input logic signed [SAT_EXT_W-1:0] v,
      input int unsigned                 w
   );
      logic signed [SAT_EXT_W-1:0] hi;
      logic signed [SAT_EXT_W-1:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/mult_fixed_complex.sv
// Combinational complex fixed-point multiplier, Q(QI.QF) in and out.
//   x_Re, x_Im : signed sample
//   h_Re, h_Im : signed coefficient
//   y_Re, y_Im : signed product, truncated toward -inf and saturated
//   overflow   : set when either component was clamped
module mult_fixed_complex
   import cmac_pkg::*;
#(
   parameter int QI = 4,
   parameter int QF = 4
) (
   input  logic signed [QI+QF-1:0] x_Re,
   input  logic signed [QI+QF-1:0] x_Im,
   input  logic signed [QI+QF-1:0] h_Re,
   input  logic signed [QI+QF-1:0] h_Im,
   output logic signed [QI+QF-1:0] y_Re,
   output logic signed [QI+QF-1:0] y_Im,
   output logic                    overflow
);

   localparam int W  = QI + QF;
   localparam int PW = 2 * W + 1;

   logic signed [2*W-1:0]       p_rr, p_ii, p_ri, p_ir;
   logic signed [PW-1:0]        re_full, im_full;
   logic signed [PW-1:0]        re_sh, im_sh;
   logic signed [SAT_EXT_W-1:0] re_ext, im_ext;
   logic signed [SAT_EXT_W-1:0] re_sat, im_sat;

   always_comb begin
      p_rr = x_Re * h_Re;
      p_ii = x_Im * h_Im;
      p_ri = x_Re * h_Im;
      p_ir = x_Im * h_Re;

      // One extra bit so the sum/difference of two products cannot wrap.
      re_full = {p_rr[2*W-1], p_rr} - {p_ii[2*W-1], p_ii};
      im_full = {p_ri[2*W-1], p_ri} + {p_ir[2*W-1], p_ir};

      re_sh = re_full >>> QF;
      im_sh = im_full >>> QF;

      re_ext = {{(SAT_EXT_W-PW){re_sh[PW-1]}}, re_sh};
      im_ext = {{(SAT_EXT_W-PW){im_sh[PW-1]}}, im_sh};

      re_sat = sat_clamp(re_ext, W);
      im_sat = sat_clamp(im_ext, W);

      y_Re     = re_sat[W-1:0];
      y_Im     = im_sat[W-1:0];
      overflow = (re_sat != re_ext) || (im_sat != im_ext);
   end

endmodule

// File: rtl/cmac_sequencer.sv
// N-tap complex dot-product engine around mult_fixed_complex.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, busy          : begin a dot product (IDLE only) / not idle
//   in_valid, in_ready   : sample/coefficient beat handshake
//   x_Re, x_Im, h_Re, h_Im : signed Q(QI.QF) operands
//   out_valid, out_ready : result handshake
//   y_Re, y_Im           : signed saturated Q(QI.QF) result
//   overflow             : any multiplier overflow or final saturation
module cmac_sequencer
   import cmac_pkg::*;
#(
   parameter int QI        = 4,
   parameter int QF        = 4,
   parameter int N_TAPS    = 8,
   parameter int ACC_GUARD = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    busy,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [QI+QF-1:0] x_Re,
   input  logic signed [QI+QF-1:0] x_Im,
   input  logic signed [QI+QF-1:0] h_Re,
   input  logic signed [QI+QF-1:0] h_Im,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [QI+QF-1:0] y_Re,
   output logic signed [QI+QF-1:0] y_Im,
   output logic                    overflow
);

   localparam int W     = QI + QF;
   localparam int ACC_W = acc_width(QI, QF, ACC_GUARD);
   localparam int CNT_W = cnt_width(N_TAPS);
   localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);

   cmac_state_t state, state_nxt;

   logic [CNT_W-1:0]        cnt;
   logic signed [W-1:0]     prod_re, prod_im;
   logic                    prod_ovf;
   logic                    pipe_v;
   logic signed [ACC_W-1:0] acc_re, acc_im;
   logic                    sticky;

   logic signed [W-1:0]         m_re, m_im;
   logic                        m_ovf;
   logic                        accept;
   logic signed [ACC_W-1:0]     acc_re_sum, acc_im_sum;
   logic signed [SAT_EXT_W-1:0] re_ext, im_ext, re_sat, im_sat;
   logic                        sticky_sum;
   logic                        clamp_any;

   mult_fixed_complex #(
      .QI (QI),
      .QF (QF)
   ) u_mult (
      .x_Re     (x_Re),
      .x_Im     (x_Im),
      .h_Re     (h_Re),
      .h_Im     (h_Im),
      .y_Re     (m_re),
      .y_Im     (m_im),
      .overflow (m_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && (cnt == LAST_TAP)) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign accept = in_valid && (state == ACCUM);

   // Accumulator update and the final saturation share one adder: in
   // DRAIN the saturated value is taken from the sum that includes the
   // last product, so no extra cycle is needed to fold it in.
   always_comb begin
      acc_re_sum = acc_re + {{ACC_GUARD{prod_re[W-1]}}, prod_re};
      acc_im_sum = acc_im + {{ACC_GUARD{prod_im[W-1]}}, prod_im};
      re_ext     = {{(SAT_EXT_W-ACC_W){acc_re_sum[ACC_W-1]}}, acc_re_sum};
      im_ext     = {{(SAT_EXT_W-ACC_W){acc_im_sum[ACC_W-1]}}, acc_im_sum};
      re_sat     = sat_clamp(re_ext, W);
      im_sat     = sat_clamp(im_ext, W);
      clamp_any  = (re_sat != re_ext) || (im_sat != im_ext);
      sticky_sum = sticky | (pipe_v & prod_ovf);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         prod_re  <= '0;
         prod_im  <= '0;
         prod_ovf <= 1'b0;
         pipe_v   <= 1'b0;
         acc_re   <= '0;
         acc_im   <= '0;
         sticky   <= 1'b0;
         y_Re     <= '0;
         y_Im     <= '0;
         overflow <= 1'b0;
      end else if ((state == IDLE) && start) begin
         cnt    <= '0;
         pipe_v <= 1'b0;
         acc_re <= '0;
         acc_im <= '0;
         sticky <= 1'b0;
      end else begin
         pipe_v <= accept;
         if (accept) begin
            prod_re  <= m_re;
            prod_im  <= m_im;
            prod_ovf <= m_ovf;
            cnt      <= cnt + 1'b1;
         end
         if (pipe_v) begin
            acc_re <= acc_re_sum;
            acc_im <= acc_im_sum;
            sticky <= sticky_sum;
         end
         if (state == DRAIN) begin
            y_Re     <= re_sat[W-1:0];
            y_Im     <= im_sat[W-1:0];
            overflow <= sticky_sum | clamp_any;
         end
      end
   end

endmodule
